// File: rtl/elevator_ctrl.sv
// SCAN elevator car scheduler: latches calls, times travel and door dwell, reports position.
// Optional homing to floor 0 after an idle period is built when ELEVATOR_HOME_EN is defined.
module elevator_ctrl #(
  parameter int FLOORS        = 8,
  parameter int FLOOR_W       = 3,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 6,
  parameter int HOME_CYCLES   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLOORS-1:0]  req,
  output logic [FLOOR_W-1:0] current_floor,
  output logic [FLOORS-1:0]  pending,
  output logic               moving,
  output logic               dir_up,
  output logic               door_open,
  output logic               floor_change
);

  localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] TRAVEL_LD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LD   = TW'(DOOR_CYCLES - 1);

  if (FLOORS < 2 || (2 ** FLOOR_W) < FLOORS || TRAVEL_CYCLES < 1 ||
      DOOR_CYCLES < 1 || HOME_CYCLES < 1) begin : g_bad_params
    $error("elevator_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_DOOR} state_t;

  state_t             state_q, state_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic [FLOORS-1:0]  pend_q, pend_d;
  logic               dir_q, dir_d;
  logic               fc_q, fc_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic [2:0]         dec;

  // Returns {next state, next direction} for the car standing at floor f.
  function automatic logic [2:0] decide(input logic [FLOORS-1:0] p,
                                        input logic [FLOOR_W-1:0] f,
                                        input logic d, input logic chk_self);
    logic above, below;
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (p[i] && (FLOOR_W'(i) > f)) above = 1'b1;
      if (p[i] && (FLOOR_W'(i) < f)) below = 1'b1;
    end
    if (chk_self && p[f])  decide = {S_DOOR, d};
    else if (d && above)   decide = {S_UP, 1'b1};
    else if (!d && below)  decide = {S_DOWN, 1'b0};
    else if (above)        decide = {S_UP, 1'b1};
    else if (below)        decide = {S_DOWN, 1'b0};
    else                   decide = {S_IDLE, d};
  endfunction

`ifdef ELEVATOR_HOME_EN
  localparam int HCW = (HOME_CYCLES > 1) ? $clog2(HOME_CYCLES) : 1;
  logic [HCW-1:0] idle_q, idle_d;
`endif

  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    pend_d  = pend_q | req;
    dir_d   = dir_q;
    fc_d    = 1'b0;
    tmr_d   = tmr_q;
    dec     = '0;
    // A call for the floor whose door is open extends the dwell instead of latching.
    if (state_q == S_DOOR) pend_d[floor_q] = pend_q[floor_q];
`ifdef ELEVATOR_HOME_EN
    idle_d = '0;
    if (state_q == S_IDLE && pend_q == '0 && floor_q != '0) begin
      if (idle_q == HCW'(HOME_CYCLES - 1)) pend_d[0] = 1'b1;
      else                                 idle_d = idle_q + HCW'(1);
    end
`endif
    case (state_q)
      S_IDLE: begin
        dec     = decide(pend_q, floor_q, dir_q, 1'b1);
        state_d = state_t'(dec[2:1]);
        dir_d   = dec[0];
      end
      S_UP, S_DOWN: begin
        if (tmr_q == '0) begin
          floor_d = (state_q == S_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
          fc_d    = 1'b1;
          dec     = decide(pend_q, floor_d, dir_q, 1'b1);
          state_d = state_t'(dec[2:1]);
          dir_d   = dec[0];
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: begin
        if (req[floor_q]) begin
          tmr_d = DOOR_LD;
        end else if (tmr_q == '0) begin
          dec     = decide(pend_q, floor_q, dir_q, 1'b0);
          state_d = state_t'(dec[2:1]);
          dir_d   = dec[0];
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
    endcase
    if (state_d == S_DOOR && state_q != S_DOOR) begin
      pend_d[floor_d] = 1'b0;
      tmr_d           = DOOR_LD;
    end else if ((state_d == S_UP || state_d == S_DOWN) && (state_d != state_q || fc_d)) begin
      tmr_d = TRAVEL_LD;
    end else if (state_d == S_IDLE) begin
      tmr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      floor_q <= '0;
      pend_q  <= '0;
      dir_q   <= 1'b1;
      fc_q    <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      pend_q  <= pend_d;
      dir_q   <= dir_d;
      fc_q    <= fc_d;
      tmr_q   <= tmr_d;
    end
  end

`ifdef ELEVATOR_HOME_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idle_q <= '0;
    else      idle_q <= idle_d;
  end
`endif

  assign current_floor = floor_q;
  assign pending       = pend_q;
  assign moving        = (state_q == S_UP) || (state_q == S_DOWN);
  assign dir_up        = dir_q;
  assign door_open     = (state_q == S_DOOR);
  assign floor_change  = fc_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Bench for elevator_ctrl: directed scenarios plus randomized calls against a behavioural car model.
module tb_elevator_ctrl;
  localparam int F  = 8;
  localparam int TC = 4;
  localparam int DC = 6;
  localparam int HC = 32;
  localparam logic [14:0] RST_VEC = {3'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0};

  logic         clk, rst;
  logic [F-1:0] req;
  logic [2:0]   current_floor;
  logic [F-1:0] pending;
  logic         moving, dir_up, door_open, floor_change;
  logic [14:0]  dut_vec;

  int errors = 0;
  int checks = 0;
  int fc_total = 0;
  bit chk_en = 0;

  elevator_ctrl #(.FLOORS(F), .FLOOR_W(3), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC),
                  .HOME_CYCLES(HC)) dut (
    .clk(clk), .rst(rst), .req(req), .current_floor(current_floor), .pending(pending),
    .moving(moving), .dir_up(dir_up), .door_open(door_open), .floor_change(floor_change));

  assign dut_vec = {current_floor, pending, moving, dir_up, door_open, floor_change};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Car model: mode 0 parked, 1 travelling, 2 door open; m_left = cycles left in the activity.
  int           m_pos, m_mode, m_left, m_home;
  bit           m_dir, m_fc;
  bit [F-1:0]   m_pend;

  task automatic m_reset();
    m_pos = 0; m_mode = 0; m_left = 0; m_home = 0; m_dir = 1; m_fc = 0; m_pend = '0;
  endtask

  task automatic m_decide(input bit [F-1:0] p, input bit self_ok, inout bit [F-1:0] np);
    int above, below;
    above = 0; below = 0;
    for (int i = 0; i < F; i++) begin
      if (p[i] && i > m_pos) above++;
      if (p[i] && i < m_pos) below++;
    end
    if (self_ok && p[m_pos]) begin
      m_mode = 2; m_left = DC; np[m_pos] = 1'b0;
    end else if ((m_dir && above > 0) || (!m_dir && below == 0 && above > 0)) begin
      m_mode = 1; m_dir = 1; m_left = TC;
    end else if (below > 0) begin
      m_mode = 1; m_dir = 0; m_left = TC;
    end else begin
      m_mode = 0;
    end
  endtask

  task automatic m_step(input bit [F-1:0] r);
    bit [F-1:0] old, np;
    old = m_pend;
    np = old | r;
    m_fc = 0;
    if (m_mode == 2) np[m_pos] = old[m_pos];
`ifdef ELEVATOR_HOME_EN
    if (m_mode == 0 && old == 0 && m_pos != 0) begin
      m_home++;
      if (m_home == HC) begin np[0] = 1'b1; m_home = 0; end
    end else begin
      m_home = 0;
    end
`endif
    case (m_mode)
      0: m_decide(old, 1'b1, np);
      1: begin
        m_left--;
        if (m_left == 0) begin
          m_pos = m_dir ? m_pos + 1 : m_pos - 1;
          m_fc = 1;
          m_decide(old, 1'b1, np);
        end
      end
      default: begin
        if (r[m_pos]) m_left = DC;
        else begin
          m_left--;
          if (m_left == 0) m_decide(old, 1'b0, np);
        end
      end
    endcase
    m_pend = np;
  endtask

  function automatic logic [14:0] m_vec();
    return {3'(m_pos), m_pend, m_mode == 1, m_dir, m_mode == 2, m_fc};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m_reset();
    else      m_step(req);
  end

  always @(negedge clk) begin
    if (floor_change === 1'b1) fc_total++;
    if (chk_en) chk("model", 32'(dut_vec), 32'(m_vec()));
  end

  task automatic step_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b0;
    step_n(2);
    rst = 1'b1;
  endtask

  task automatic wait_door(input bit want, input string name);
    for (int n = 0; n < 300 && door_open !== want; n++) @(negedge clk);
    chk(name, 32'(door_open), 32'(want));
  endtask

  initial begin
    int fc_start;
    rst = 1'b0;
    req = '0;
    step_n(2);
    chk_en = 1;
    chk("reset_state", 32'(dut_vec), 32'(RST_VEC));

    // Basic call to floor 2
    do_reset();
    req = 8'b0000_0100;
    step_n(1); req = '0;
    chk("basic_pend_e1", 32'(pending), 32'h04);
    chk("basic_idle_e1", 32'(moving), 0);
    step_n(1);
    chk("basic_moving_e2", 32'(moving), 1);
    step_n(4);
    chk("basic_floor1_e6", 32'({current_floor, floor_change}), 32'({3'd1, 1'b1}));
    step_n(1);
    chk("basic_strobe_e7", 32'(floor_change), 0);
    step_n(3);
    chk("basic_arrive_e10", 32'({current_floor, door_open, pending, floor_change}),
        32'({3'd2, 1'b1, 8'd0, 1'b1}));
    step_n(5);
    chk("basic_door_e15", 32'(door_open), 1);
    step_n(1);
    chk("basic_idle_e16", 32'({moving, door_open}), 0);

    // Door extension at floor 2
    do_reset();
    req = 8'b0000_0100;
    step_n(1); req = '0;
    step_n(12);
    req = 8'b0000_0100;
    step_n(1); req = '0;
    for (int k = 0; k < 6; k++) begin
      chk("ext_door_held", 32'({door_open, pending[2]}), 32'({1'b1, 1'b0}));
      step_n(1);
    end
    chk("ext_door_closed", 32'(door_open), 0);

    // Same-floor call while parked at floor 0
    do_reset();
    req = 8'b0000_0001;
    step_n(1); req = '0;
    chk("same_pend_e1", 32'({pending, floor_change}), 32'({8'h01, 1'b0}));
    step_n(1);
    chk("same_door_e2", 32'({current_floor, door_open, floor_change, pending}),
        32'({3'd0, 1'b1, 1'b0, 8'd0}));

    // SCAN ordering: heading to 5, call at 1 appears while at 3
    do_reset();
    req = 8'b0010_0000;
    step_n(1); req = '0;
    for (int n = 0; n < 100 && current_floor !== 3'd3; n++) @(negedge clk);
    chk("scan_at3", 32'({current_floor, moving, dir_up}), 32'({3'd3, 1'b1, 1'b1}));
    #1 fc_start = fc_total;
    req = 8'b0000_0010;
    step_n(1); req = '0;
    wait_door(1'b1, "scan_door5_wait");
    chk("scan_first5", 32'({current_floor, dir_up}), 32'({3'd5, 1'b1}));
    wait_door(1'b0, "scan_door5_end");
    chk("scan_reverse", 32'({dir_up, moving}), 32'({1'b0, 1'b1}));
    wait_door(1'b1, "scan_door1_wait");
    #1;
    chk("scan_then1", 32'(current_floor), 1);
    chk("scan_strobes", 32'(fc_total - fc_start), 6);

    // Asynchronous reset mid-travel
    do_reset();
    req = 8'b1000_0000;
    step_n(1); req = '0;
    for (int n = 0; n < 100 && current_floor !== 3'd4; n++) @(negedge clk);
    step_n(1);
    chk("midrst_pre", 32'({current_floor, moving}), 32'({3'd4, 1'b1}));
    #2 rst = 1'b0;
    #1 chk("midrst_now", 32'(dut_vec), 32'(RST_VEC));
    step_n(1);
    rst = 1'b1;
    step_n(1);
    chk("midrst_after", 32'(dut_vec), 32'(RST_VEC));

    // Randomized calls with occasional resets
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0)       req = 8'($urandom) & 8'($urandom);
      else if ($urandom_range(0, 5) == 0)  req = 8'(1) << $urandom_range(0, 7);
      else                                 req = '0;
      if ($urandom_range(0, 699) == 0) begin
        #2 rst = 1'b0;
        #1 chk("rand_rst", 32'(dut_vec), 32'(RST_VEC));
        @(negedge clk);
        rst = 1'b1;
      end
    end
    step_n(1);
    req = '0;

`ifdef ELEVATOR_HOME_EN
    do_reset();
    req = 8'b0000_1000;
    step_n(1); req = '0;
    wait_door(1'b1, "home_door3_wait");
    wait_door(1'b0, "home_door3_end");
    chk("home_parked3", 32'({current_floor, moving}), 32'({3'd3, 1'b0}));
    step_n(HC - 1);
    chk("home_not_yet", 32'(pending), 0);
    step_n(1);
    chk("home_called", 32'(pending), 32'h01);
    wait_door(1'b1, "home_door0_wait");
    chk("home_floor0", 32'(current_floor), 0);
    wait_door(1'b0, "home_door0_end");
    chk("home_idle0", 32'({current_floor, moving}), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
